// File: rtl/reg_dump_uart.sv
// ---------------------------------------------------------------------------
// reg_dump_uart
//
// Debug read-out engine for the MIPS register file. When start is seen in
// IDLE it walks register indices FIRST_REG..LAST_REG through the register
// file's read port. For each index it snapshots the 32-bit value and sends a
// 5-byte record over a UART 8N1 line: the index byte {3'b000, idx}, then the
// value MSB byte first. It only reads the register file and never writes it.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2 or more)
//   FIRST_REG     first register index dumped (0..31)
//   LAST_REG      last register index dumped (FIRST_REG..31)
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high reset
//   start    in   dump request, only looked at in IDLE
//   rd_addr  out  [4:0]  register-file read address
//   rd_data  in   [31:0] register-file read data (combinational from rd_addr)
//   tx       out  UART serial output, idle high
//   busy     out  high while a dump is in progress
//   done     out  one-cycle pulse in the cycle after the final stop bit
// ---------------------------------------------------------------------------
module reg_dump_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIRST_REG    = 0,
  parameter int LAST_REG     = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0]        LAST_IDX  = 5'(LAST_REG);
  localparam logic [3:0]        STOP_BIT  = 4'd9;  // bit slots: 0 start, 1..8 data, 9 stop
  localparam logic [2:0]        LAST_BYTE = 3'd4;  // bytes 0..4 of a record

  // Loading the buffer happens on the ADDR->SEND edge, so there is no
  // separate LOAD state to occupy a cycle.
  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    SEND
  } stateType;

  stateType          state,    stateNext;
  logic [BAUD_W-1:0] baudCnt,  baudCntNext;
  logic [3:0]        bitCnt,   bitCntNext;
  logic [2:0]        byteCnt,  byteCntNext;
  logic [39:0]       shiftBuf, shiftBufNext;  // current byte always in [39:32]
  logic [4:0]        addr,     addrNext;
  logic              txReg,    txNext;
  logic              doneReg,  doneNext;

  logic              bitEnd;
  logic [7:0]        nextByte;
  logic [2:0]        dataIdx;

  assign bitEnd = (baudCnt == BAUD_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    stateNext    = state;
    baudCntNext  = baudCnt;
    bitCntNext   = bitCnt;
    byteCntNext  = byteCnt;
    shiftBufNext = shiftBuf;
    addrNext     = addr;
    doneNext     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext = ADDR;
          addrNext  = FIRST_IDX;
        end
      end

      ADDR: begin
        // rd_data has had the whole ADDR cycle to settle; snapshot it so
        // later changes on the read port cannot disturb the record.
        stateNext    = SEND;
        shiftBufNext = {3'b000, addr, rd_data};
        baudCntNext  = '0;
        bitCntNext   = '0;
        byteCntNext  = '0;
      end

      SEND: begin
        if (!bitEnd) begin
          baudCntNext = baudCnt + 1'b1;
        end else begin
          baudCntNext = '0;
          if (bitCnt != STOP_BIT) begin
            bitCntNext = bitCnt + 4'd1;
          end else begin
            bitCntNext = '0;
            if (byteCnt != LAST_BYTE) begin
              // Next byte follows the stop bit with no idle gap.
              byteCntNext  = byteCnt + 3'd1;
              shiftBufNext = {shiftBuf[31:0], 8'h00};
            end else begin
              byteCntNext = '0;
              if (addr < LAST_IDX) begin
                addrNext  = addr + 5'd1;
                stateNext = ADDR;
              end else begin
                stateNext = IDLE;
                doneNext  = 1'b1;
              end
            end
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // The serial line is registered: its next value is derived from the next
  // counter/buffer values so the output is glitch-free and lines up exactly
  // with the state it belongs to.
  assign nextByte = shiftBufNext[39:32];
  assign dataIdx  = 3'(bitCntNext - 4'd1);

  always_comb begin
    txNext = 1'b1;
    if (stateNext == SEND) begin
      if (bitCntNext == 4'd0) begin
        txNext = 1'b0;
      end else if (bitCntNext == STOP_BIT) begin
        txNext = 1'b1;
      end else begin
        txNext = nextByte[dataIdx];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitCnt   <= '0;
      byteCnt  <= '0;
      shiftBuf <= '0;
      addr     <= FIRST_IDX;
      txReg    <= 1'b1;
      doneReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudCntNext;
      bitCnt   <= bitCntNext;
      byteCnt  <= byteCntNext;
      shiftBuf <= shiftBufNext;
      addr     <= addrNext;
      txReg    <= txNext;
      doneReg  <= doneNext;
    end
  end

  assign rd_addr = addr;
  assign tx      = txReg;
  assign busy    = (state != IDLE);
  assign done    = doneReg;

endmodule
